// File: rtl/dvi_tx_timing_ctrl.sv
// Purpose: DVI video timing generator and pixel scheduler; starts and stops only on frame boundaries.
// Latency: 1 cycle from the h/v counters to den/hsync/vsync/frame_start/pixel_data.
// Backpressure: none, the raster free-runs; an empty FIFO is read anyway and flagged as underflow.
//
// Ports:
//   pixel_clock, reset      - sole clock, synchronous active-high reset
//   enable                  - level request to transmit frames (acted on at frame boundaries)
//   underflow_clr           - one-cycle pulse clearing the sticky underflow flag
//   fifo_empty, fifo_data   - pixel FIFO status and read data (data valid the cycle after fifo_rd_en)
//   fifo_rd_en              - FIFO read strobe, combinational from state and counters
//   den, hsync, vsync       - registered timing outputs to the TMDS encoders
//   pixel_data              - {R,G,B} pixel aligned with den, zero outside den and on underflow
//   frame_start             - one-cycle pulse with the first den of each frame
//   running                 - high while a frame is being generated
//   underflow               - sticky, set when a read hits an empty FIFO
module dvi_tx_timing_ctrl #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        underflow_clr,
  input  logic        fifo_empty,
  input  logic [23:0] fifo_data,
  output logic        fifo_rd_en,
  output logic        den,
  output logic        hsync,
  output logic        vsync,
  output logic [23:0] pixel_data,
  output logic        frame_start,
  output logic        running,
  output logic        underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t      state;
  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        pix_ok;     // slot had a real FIFO word; gates fifo_data onto the pins

  logic active_now;
  logic hs_region;
  logic vs_region;
  logic last_pix;
  logic h_wrap;

  assign h_wrap     = (h_cnt == H_LAST);
  assign last_pix   = h_wrap && (v_cnt == V_LAST);
  assign active_now = (state != IDLE) && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign hs_region  = (state != IDLE) && (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  assign vs_region  = (state != IDLE) && (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

  // Read whenever the raster needs a pixel, even if the FIFO is empty.
  assign fifo_rd_en = active_now;

  // The FIFO's own read register supplies the word in the cycle after fifo_rd_en,
  // which is exactly when den is up, so the pixel only needs a registered gate.
  assign pixel_data = pix_ok ? fifo_data : 24'h000000;

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      state       <= IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      den         <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      frame_start <= 1'b0;
      pix_ok      <= 1'b0;
      underflow   <= 1'b0;
      running     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          h_cnt   <= '0;
          v_cnt   <= '0;
          running <= enable;
          if (enable) state <= RUN;
        end
        RUN, STOP: begin
          if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
          end else begin
            h_cnt <= h_cnt + 12'd1;
          end
          // enable only matters at the last pixel; mid-frame it just moves
          // between RUN and STOP, which generate identical timing.
          if (last_pix) begin
            state   <= enable ? RUN : IDLE;
            running <= enable;
          end else begin
            state   <= enable ? RUN : STOP;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          h_cnt   <= '0;
          v_cnt   <= '0;
          running <= 1'b0;
        end
      endcase

      den         <= active_now;
      hsync       <= hs_region ? HS_POL : ~HS_POL;
      vsync       <= vs_region ? VS_POL : ~VS_POL;
      frame_start <= active_now && (h_cnt == 12'd0) && (v_cnt == 12'd0);
      pix_ok      <= active_now && !fifo_empty;
      // A new underflow in the same cycle as a clear keeps the flag set.
      underflow   <= (active_now && fifo_empty) || (underflow && !underflow_clr);
    end
  end

endmodule

// File: tb/tb_dvi_tx_timing_ctrl.sv
module tb_dvi_tx_timing_ctrl;

  localparam int HA = 4, HFP = 1, HSW = 2, HBP = 1;
  localparam int VA = 3, VFP = 1, VSW = 1, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP;   // 8
  localparam int VT = VA + VFP + VSW + VBP;   // 6
  localparam int FT = HT * VT;                // 48
  localparam bit HSP = 1'b1;
  localparam bit VSP = 1'b1;

  logic        pixel_clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        underflow_clr = 1'b0;
  logic        fifo_empty = 1'b0;
  logic [23:0] fifo_data = 24'h0;
  logic        fifo_rd_en, den, hsync, vsync, frame_start, running, underflow;
  logic [23:0] pixel_data;

  dvi_tx_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP)
  ) dut (
    .pixel_clock(pixel_clock), .reset(reset), .enable(enable),
    .underflow_clr(underflow_clr), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .den(den), .hsync(hsync), .vsync(vsync),
    .pixel_data(pixel_data), .frame_start(frame_start), .running(running),
    .underflow(underflow)
  );

  always #5 pixel_clock = ~pixel_clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: incrementing data, shares the block reset, word appears after the read edge.
  int fifo_next = 0;
  always @(posedge pixel_clock) begin
    if (fifo_rd_en && !fifo_empty && !reset) begin
      fifo_data <= 24'(fifo_next);
      fifo_next <= fifo_next + 1;
    end
  end

  // Reference model: a frame is a linear position 0..FT-1; h and v come from div/mod.
  typedef struct packed {
    logic        den, hs, vs, fs, run, uf, rd;
    logic [23:0] pix;
  } exp_t;

  exp_t sbq[$];
  bit   m_run = 1'b0;
  int   m_pos = 0;
  bit   m_uf  = 1'b0;
  int   m_pix = 0;

  function automatic bit in_active(input int p);
    return ((p % HT) < HA) && ((p / HT) < VA);
  endfunction

  always @(posedge pixel_clock) begin
    exp_t e;
    int   h, v;
    bit   act;
    e = '0;
    if (reset) begin
      m_run = 1'b0;
      m_pos = 0;
      m_uf  = 1'b0;
      e.hs  = !HSP;
      e.vs  = !VSP;
    end else begin
      h   = m_pos % HT;
      v   = m_pos / HT;
      act = m_run && in_active(m_pos);
      e.den = act;
      e.hs  = (m_run && h >= HA + HFP && h < HA + HFP + HSW) ? HSP : !HSP;
      e.vs  = (m_run && v >= VA + VFP && v < VA + VFP + VSW) ? VSP : !VSP;
      e.fs  = act && (m_pos == 0);
      if (act && !fifo_empty) begin
        e.pix = 24'(m_pix);
        m_pix++;
      end
      m_uf = (act && fifo_empty) || (m_uf && !underflow_clr);
      e.uf = m_uf;
      if (!m_run) begin
        if (enable) begin
          m_run = 1'b1;
          m_pos = 0;
        end
      end else if (m_pos == FT - 1) begin
        m_run = enable;
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end
    e.run = m_run;
    e.rd  = m_run && in_active(m_pos);
    sbq.push_back(e);
  end

  // Monitor: every cycle the DUT presents a full output vector; compare on the falling edge.
  always @(negedge pixel_clock) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("den",         24'(den),         24'(e.den));
      chk("hsync",       24'(hsync),       24'(e.hs));
      chk("vsync",       24'(vsync),       24'(e.vs));
      chk("frame_start", 24'(frame_start), 24'(e.fs));
      chk("running",     24'(running),     24'(e.run));
      chk("underflow",   24'(underflow),   24'(e.uf));
      chk("fifo_rd_en",  24'(fifo_rd_en),  24'(e.rd));
      chk("pixel_data",  pixel_data,       e.pix);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge pixel_clock);
      #2;
    end
  endtask

  // Returns 2 time units after the edge that leaves the model at position p while running;
  // inputs set afterwards apply to the slot at position p.
  task automatic wait_pos(input int p);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge pixel_clock);
      #2;
      hit = m_run && (m_pos == p);
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL wait_pos: position %0d not reached within 200 cycles", p);
    end
  endtask

  initial begin
    int nrd, nfs;
    bit idle_hit;

    // Reset, then idle with enable low: nothing may be read.
    step(4);
    reset = 1'b0;
    step(5);
    chk("idle_rd_en", 24'(fifo_rd_en), 24'd0);
    chk("idle_running", 24'(running), 24'd0);

    // Start latency: rd_en one cycle after enable, den and frame_start after two.
    enable = 1'b1;
    step(1);
    chk("start_rd_en", 24'(fifo_rd_en), 24'd1);
    chk("start_den", 24'(den), 24'd0);
    step(1);
    chk("start_frame_start", 24'(frame_start), 24'd1);
    chk("start_den2", 24'(den), 24'd1);

    // Three back-to-back frames: 12 reads and one frame_start per 48 cycles.
    wait_pos(0);
    for (int f = 0; f < 3; f++) begin
      nrd = 0;
      nfs = 0;
      for (int c = 0; c < FT; c++) begin
        @(negedge pixel_clock);
        nrd += int'(fifo_rd_en);
        nfs += int'(frame_start);
      end
      chk("reads_per_frame", 24'(nrd), 24'd12);
      chk("starts_per_frame", 24'(nfs), 24'd1);
    end

    // Drop enable on line 1: the frame completes, then the block idles.
    wait_pos(HT);
    enable = 1'b0;
    idle_hit = 1'b0;
    for (int i = 0; i < 200 && !idle_hit; i++) begin
      step(1);
      idle_hit = !m_run;
    end
    chk("stop_reached_idle", 24'(idle_hit), 24'd1);
    step(1);
    chk("stop_running", 24'(running), 24'd0);
    step(8);

    // Drop then re-raise within a frame: STOP returns to RUN with no gap.
    enable = 1'b1;
    wait_pos(20);
    enable = 1'b0;
    wait_pos(30);
    enable = 1'b1;
    wait_pos(FT - 1);
    step(2);
    chk("restart_frame_start", 24'(frame_start), 24'd1);

    // Underflow on the 3rd active pixel of line 0.
    wait_pos(2);
    fifo_empty = 1'b1;
    step(1);
    fifo_empty = 1'b0;
    @(negedge pixel_clock);
    chk("uf_pixel_zero", pixel_data, 24'd0);
    chk("uf_den_high", 24'(den), 24'd1);
    chk("uf_set", 24'(underflow), 24'd1);
    step(5);
    chk("uf_sticky", 24'(underflow), 24'd1);
    underflow_clr = 1'b1;
    step(1);
    underflow_clr = 1'b0;
    chk("uf_cleared", 24'(underflow), 24'd0);

    // Simultaneous set and clear: set wins.
    wait_pos(2);
    fifo_empty = 1'b1;
    underflow_clr = 1'b1;
    step(1);
    fifo_empty = 1'b0;
    underflow_clr = 1'b0;
    chk("uf_set_beats_clr", 24'(underflow), 24'd1);

    // Reset mid-active-line, then restart from (0,0) with enable held.
    wait_pos(HT + 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rst_den", 24'(den), 24'd0);
    chk("rst_hsync", 24'(hsync), 24'(!HSP));
    chk("rst_vsync", 24'(vsync), 24'(!VSP));
    chk("rst_running", 24'(running), 24'd0);
    chk("rst_rd_en", 24'(fifo_rd_en), 24'd0);
    chk("rst_underflow", 24'(underflow), 24'd0);
    step(1);
    chk("rst_restart_rd_en", 24'(fifo_rd_en), 24'd1);
    step(1);
    chk("rst_restart_frame_start", 24'(frame_start), 24'd1);
    step(60);

    // Randomized traffic: enable toggles, sparse empties, clears and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) enable = ~enable;
      fifo_empty    = ($urandom_range(15) == 0);
      underflow_clr = ($urandom_range(7) == 0);
      reset         = ($urandom_range(399) == 0);
      step(1);
    end
    reset = 1'b0;
    fifo_empty = 1'b0;
    underflow_clr = 1'b0;
    step(3);
    @(negedge pixel_clock);
    @(negedge pixel_clock);
    chk("fifo_reads_total", 24'(fifo_next), 24'(m_pix));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
